// File: rtl/lfsr_rand.sv
// Fibonacci LFSR random source with a rejection-sampling range generator.
// A req yields one uniform value in [0, range_max_i], delivered with a one-cycle ack_o.
module lfsr_rand #(
    parameter int            N         = 8,
    parameter logic [N-1:0]  TAPS      = 8'hB8,
    parameter logic [N-1:0]  SEED      = '0,
    parameter int            MAX_TRIES = 16
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         en_i,
    input  logic         load_i,
    input  logic [N-1:0] seed_i,
    input  logic         req_i,
    input  logic [N-1:0] range_max_i,
    output logic         ack_o,
    output logic [N-1:0] value_o,
    output logic         busy_o,
    output logic [N-1:0] state_o
);
    localparam int            TW        = $clog2(MAX_TRIES) + 1;
    localparam logic [TW-1:0] LAST_TRY  = TW'(MAX_TRIES - 1);
    // XNOR feedback locks up on all-ones, so that value is never allowed in.
    localparam logic [N-1:0]  SEED_SAFE = (SEED == '1) ? '0 : SEED;

    typedef enum logic [1:0] {IDLE, DRAW, DONE} fsm_t;

    fsm_t          fsm_q;
    logic [N-1:0]  ps_q, ps_d;
    logic [N-1:0]  lim_q, mask, cand, value_q;
    logic [TW-1:0] tries_q;
    logic          ack_q, busy_q, fb;

    assign fb = ~^(ps_q & TAPS);

    always_comb begin
        ps_d = ps_q;
        if (load_i)
            ps_d = (seed_i == '1) ? '0 : seed_i;
        else if (en_i || fsm_q == DRAW)
            ps_d = {ps_q[N-2:0], fb};
    end

    // Smearing lim rightward gives the smallest 2^k-1 covering it.
    always_comb begin
        mask = lim_q;
        for (int i = 1; i < N; i++)
            mask = mask | (lim_q >> i);
    end

    assign cand = ps_q & mask;

    always_ff @(posedge clk_i) begin
        if (reset_i) ps_q <= SEED_SAFE;
        else         ps_q <= ps_d;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            fsm_q   <= IDLE;
            lim_q   <= '0;
            tries_q <= '0;
            value_q <= '0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            case (fsm_q)
                IDLE: if (req_i) begin
                    lim_q   <= range_max_i;
                    tries_q <= '0;
                    busy_q  <= 1'b1;
                    fsm_q   <= DRAW;
                end
                DRAW: begin
                    if (cand <= lim_q) begin
                        value_q <= cand;
                        ack_q   <= 1'b1;
                        fsm_q   <= DONE;
                    end else if (tries_q == LAST_TRY) begin
                        // cand > lim fills lim's top bit, so cand>>1 stays below lim.
                        value_q <= cand >> 1;
                        ack_q   <= 1'b1;
                        fsm_q   <= DONE;
                    end else begin
                        tries_q <= tries_q + 1'b1;
                    end
                end
                DONE: begin
                    busy_q <= 1'b0;
                    fsm_q  <= IDLE;
                end
                default: fsm_q <= IDLE;
            endcase
        end
    end

    assign ack_o   = ack_q;
    assign value_o = value_q;
    assign busy_o  = busy_q;
    assign state_o = ps_q;
endmodule

// File: tb/tb_lfsr_rand.sv
// Bench for lfsr_rand: directed scenarios on several builds, then randomized
// free-run/load/draw traffic against a parity-and-loop reference model.
module tb_lfsr_rand;
    logic       clk = 1'b0, reset = 1'b1, en = 1'b0, load = 1'b0, req = 1'b0;
    logic [7:0] seed = '0, rmax = '0;

    logic       ack, busy, ack2, busy2, ackf, busyf, ack3, busy3;
    logic [7:0] value, state, value2, state2, valuef, statef;
    logic [2:0] value3, state3;

    int n_tests = 0, n_fail = 0;

    always #5 clk = ~clk;

    lfsr_rand dut (
        .clk_i(clk), .reset_i(reset), .en_i(en), .load_i(load), .seed_i(seed),
        .req_i(req), .range_max_i(rmax), .ack_o(ack), .value_o(value),
        .busy_o(busy), .state_o(state));

    lfsr_rand #(.MAX_TRIES(2)) dut_mt2 (
        .clk_i(clk), .reset_i(reset), .en_i(en), .load_i(load), .seed_i(seed),
        .req_i(req), .range_max_i(rmax), .ack_o(ack2), .value_o(value2),
        .busy_o(busy2), .state_o(state2));

    lfsr_rand #(.SEED(8'hFF)) dut_ff (
        .clk_i(clk), .reset_i(reset), .en_i(en), .load_i(load), .seed_i(seed),
        .req_i(req), .range_max_i(rmax), .ack_o(ackf), .value_o(valuef),
        .busy_o(busyf), .state_o(statef));

    lfsr_rand #(.N(3), .TAPS(3'b110), .SEED(3'b000)) dut3 (
        .clk_i(clk), .reset_i(reset), .en_i(en), .load_i(1'b0), .seed_i(3'b000),
        .req_i(1'b0), .range_max_i(3'b000), .ack_o(ack3), .value_o(value3),
        .busy_o(busy3), .state_o(state3));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Next state: shift left, feed in 1 when the tapped bits hold an even number of ones.
    function automatic int m_next(input int p, input int taps, input int n);
        int fb;
        fb = ($countones(p & taps) % 2 == 0) ? 1 : 0;
        return ((p << 1) | fb) & ((1 << n) - 1);
    endfunction

    // Whole draw from starting state p: result, req-to-ack edge count, state at ack.
    function automatic void m_draw(input int p, input int lim, input int maxt,
                                   output int val, output int lat, output int pend);
        int m = 0;
        int cand;
        while (m < lim) m = m * 2 + 1;
        val = 0;
        lat = 0;
        for (int t = 0; t < maxt; t++) begin
            cand = p & m;
            p = m_next(p, 'hB8, 8);
            if (cand <= lim) begin
                val = cand; lat = t + 2;
                break;
            end
            if (t == maxt - 1) begin
                val = cand >> 1; lat = t + 2;
            end
        end
        pend = p;
    endfunction

    logic [7:0] seq8 [0:4] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1E};
    logic [2:0] seq3 [0:6] = '{3'd1, 3'd3, 3'd6, 3'd5, 3'd2, 3'd4, 3'd0};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int mps, m3, a1, a2, bc, v1, v2, cnt, first, second, n, val, lat, pend, lim;

        // Reset, with en high to show reset wins.
        reset = 1'b1; en = 1'b1;
        tick(); tick();
        chk("rst_state", state, 0);
        chk("rst_state3", state3, 0);
        chk("rst_seed_ff", statef, 0);
        chk("rst_ack", ack, 0);
        chk("rst_value", value, 0);
        chk("rst_busy", busy, 0);

        reset = 1'b0;
        mps = 0; m3 = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            mps = m_next(mps, 'hB8, 8);
            m3  = m_next(m3, 'b110, 3);
            if (i < 5) chk("seq8", state, seq8[i]);
            else       chk("run8", state, mps);
            if (i < 7) chk("seq3", state3, seq3[i]);
            else       chk("run3", state3, m3);
            chk("no_lockup3", state3 == 3'd7, 0);
        end

        en = 1'b0; load = 1'b1; seed = 8'hFF;
        tick();
        chk("load_ff_guard", state, 0);

        // Rejection: 6 and 5 rejected, 2 accepted; MAX_TRIES=2 forces 5>>1.
        seed = 8'h06;
        tick();
        load = 1'b0; req = 1'b1; rmax = 8'd4;
        tick();
        req = 1'b0;
        chk("busy_after_req", busy, 1);
        a1 = 0; a2 = 0; bc = 0; v1 = 0; v2 = 0;
        for (int k = 1; k <= 8; k++) begin
            if (ack && a1 == 0) begin a1 = k; v1 = value; end
            if (ack2 && a2 == 0) begin a2 = k; v2 = value2; end
            if (busy) bc++;
            if (k < 8) tick();
        end
        chk("rej_lat", a1, 4);
        chk("rej_value", v1, 2);
        chk("rej_busy_cycles", bc, 4);
        m_draw(6, 4, 16, val, lat, pend);
        chk("rej_state_after", state, pend);
        chk("forced_lat", a2, 3);
        chk("forced_value", v2, 2);

        // Reset while drawing: no ack, result cleared.
        req = 1'b1; rmax = 8'd4;
        tick();
        req = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        chk("midrst_ack", ack, 0);
        chk("midrst_value", value, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_state", state, 0);
        reset = 1'b0;
        cnt = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            cnt += int'(ack);
        end
        chk("midrst_no_ack", cnt, 0);
        chk("midrst_idle", busy, 0);

        // range_max = 0
        req = 1'b1; rmax = 8'd0;
        tick();
        req = 1'b0;
        a1 = 0; v1 = -1;
        for (int k = 1; k <= 4; k++) begin
            if (ack && a1 == 0) begin a1 = k; v1 = value; end
            if (k < 4) tick();
        end
        chk("zero_lat", a1, 2);
        chk("zero_value", v1, 0);

        // req held high across the ack
        req = 1'b1; rmax = 8'd0;
        tick();
        first = 0; second = 0;
        for (int k = 1; k <= 10; k++) begin
            if (ack) begin
                if (first == 0) first = k;
                else if (second == 0) begin second = k; req = 1'b0; end
            end
            if (k < 10) tick();
        end
        req = 1'b0;
        chk("held_first", first, 2);
        chk("held_gap", second - first, 3);

        reset = 1'b1;
        tick();
        reset = 1'b0;
        mps = 0;

        for (int t = 0; t < 30; t++) begin
            n = $urandom_range(1, 4);
            for (int g = 0; g < n; g++) begin
                en   = 1'($urandom % 2);
                load = ($urandom % 6 == 0);
                seed = ($urandom % 3 == 0) ? 8'hFF : 8'($urandom);
                tick();
                if (load)    mps = (seed == 8'hFF) ? 0 : int'(seed);
                else if (en) mps = m_next(mps, 'hB8, 8);
                chk("rnd_state", state, mps);
                chk("rnd_idle", {ack, busy}, 0);
            end
            en = 1'b0; load = 1'b0; req = 1'b1;
            case ($urandom % 4)
                0:       rmax = 8'd0;
                1:       rmax = 8'd255;
                default: rmax = 8'($urandom);
            endcase
            lim = int'(rmax);
            tick();
            req = 1'b0;
            m_draw(mps, lim, 16, val, lat, pend);
            n = 1;
            while (!ack && n < 24) begin
                tick();
                n++;
            end
            chk("rnd_lat", n, lat);
            chk("rnd_value", value, val);
            chk("rnd_in_range", int'(value) <= lim, 1);
            chk("rnd_state_ack", state, pend);
            mps = pend;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/lfsr_rand.md
# lfsr_rand

Parametrised Fibonacci LFSR with a tap-mask polynomial, runtime seed load and lock-up protection. It also contains a request/acknowledge range generator that returns a uniformly distributed value in [0, range_max] by rejection sampling, with a bounded retry count. Game logic uses it as the shared random source for spawn positions, obstacle heights and timing jitter, in place of the fixed 3-bit free-running LFSR.

## Interface
Parameters:
- N, 8: state and output width; N >= 2.
- TAPS, 8'hB8: feedback tap mask; bit i set means state bit i is XNORed into feedback.
- SEED, 0: state loaded on reset.
- MAX_TRIES, 16: rejection attempts before forced acceptance; >= 1.

Ports:
- clk, input, 1: clock; all logic is rising-edge.
- reset, input, 1: synchronous, active-high.
- en, input, 1: free-run advance of the LFSR by one step per cycle.
- load, input, 1: load seed into the state.
- seed, input, N: value to load.
- req, input, 1: request a ranged value; sampled only in IDLE.
- range_max, input, N: inclusive upper bound; sampled with req.
- ack, output, 1: one-cycle pulse; value is valid.
- value, output, N: ranged result; holds until the next ack.
- busy, output, 1: high in DRAW and DONE.
- state, output, N: raw LFSR state (ps).

## Operation
- Feedback: fb = XNOR-reduce(ps & TAPS), so an all-zero input to the XNOR reduction gives 1. The next state is ns = {ps[N-2:0], fb}.
- Lock-up state: all-ones. Any attempt to enter it through reset (SEED) or through load (seed) loads all-zeros instead.
- State-update priority: reset > load > advance.
  - Advance occurs when (en | state==DRAW).
  - load during DRAW replaces ps. The draw continues from the loaded value on the next cycle.
- FSM states: IDLE, DRAW, DONE.
- IDLE: when req=1, latch lim = range_max and mask = smallest 2^k-1 >= lim (mask = 0 when lim = 0). Clear the try counter and go to DRAW.
- DRAW, once per cycle:
  - Compute cand = ps & mask.
  - If cand <= lim: value <= cand, go to DONE.
  - Else if tries == MAX_TRIES-1: value <= cand >> 1, go to DONE. This result is always <= lim.
  - Else: tries++, stay in DRAW.
  - ps advances every DRAW cycle.
- DONE: ack=1 for exactly one cycle, then go to IDLE. A req arriving in DRAW or DONE is ignored and is not queued.
- Try counter width: $clog2(MAX_TRIES)+1.
- Width rules:
  - The comparison cand <= lim is unsigned, N bits.
  - The mask is computed combinationally from the latched lim by OR-smearing lim rightward.

## Timing
- Reset values: ps = SEED (0 if SEED is all-ones), FSM = IDLE, ack = 0, value = 0, busy = 0, tries = 0.
- state shows ps. A load or advance at edge k is visible after edge k.
- req sampled at edge k: busy is high after edge k, and the first candidate is evaluated from ps as it stands after edge k.
- Accepted at edge k+j (j >= 1): value updates and ack is high for the cycle after edge k+j.
- Minimum req-to-ack latency is 2 edges. Maximum is MAX_TRIES+1 edges.
- back-to-back: the earliest a new req can be accepted is the cycle after ack, when the FSM is back in IDLE.
- reset asserted mid-DRAW or during DONE: the next edge forces IDLE with ack=0 and value=0. No partial result is delivered.
- en during IDLE advances ps. en during DRAW or DONE is redundant in DRAW and honoured in DONE.

## Test plan
- Reset and free-run, with N=3, TAPS=3'b110, SEED=0, en=1: state after reset 0, then 1,3,6,5,2,4,0,… Period 7; 7 never appears in 20 cycles.
- Default parameters, en=1 from reset: state sequence 00, 01, 03, 07, 0F, 1E.
- Lock-up guard: load=1, seed=8'hFF → state=00 next cycle. With SEED=8'hFF in a reset build, post-reset state=00.
- Rejection sampling: load seed=06, then req with range_max=4 (mask 7), en=0.
  - Candidates 6 and 5 are rejected; candidate 2 (state 1A) is accepted.
  - value=2, ack 4 edges after req, busy high for 4 cycles.
- Forced acceptance: same stimulus as the previous scenario with MAX_TRIES=2 → value=2 (5>>1) and ack 3 edges after req.
- Boundaries:
  - range_max=0 → value=0 with ack 2 edges after req.
  - req held high across ack → second ack arrives no earlier than 2 edges after the first ack's cycle.
  - reset pulsed while busy → ack never asserts; value=0, FSM in IDLE.
